// File: rtl/simplerisc_pkg.sv
// Shared constants and types for the writeback stage.
package simplerisc_pkg;

  localparam int unsigned RA_REG = 15;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } wb_state_t;

  typedef struct packed {
    logic              is_wb;
    logic [REG_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback buffer; exposes every slot so the owner can build hazard masks.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0][WIDTH-1:0] slots,
  output logic [DEPTH-1:0]            slot_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]            rd_ptr;
  logic [PTR_W-1:0]            wr_ptr;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            vld;
  logic [CNT_W-1:0]            cnt;
  logic                        push_ok;
  logic                        pop_ok;

  assign full       = (cnt == CNT_W'(DEPTH));
  assign empty      = (cnt == '0);
  assign count      = cnt;
  assign rd_data    = mem[rd_ptr];
  assign slots      = mem;
  assign slot_valid = vld;

  // A push into a full buffer is legal only when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Storage, pointers and occupancy; when both hit the same slot the push wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      mem    <= '0;
      vld    <= '0;
      cnt    <= '0;
    end else begin
      if (pop_ok) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: buffers completed instructions and retires them in order to the register file.
module wb_unit #(
  parameter int unsigned WB_DEPTH = 2,
  parameter int unsigned RA_REG   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_ld_result,
  input  logic        in_is_wb,
  input  logic        in_is_ld,
  input  logic        in_is_call,
  output logic        rf_wen,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic        rf_ack,
  output logic [15:0] pending_mask,
  output logic        retired,
  output logic [15:0] retire_count
);

  import simplerisc_pkg::*;

  localparam int unsigned      CNT_W  = $clog2(WB_DEPTH) + 1;
  localparam logic [REG_W-1:0] RA_IDX = REG_W'(RA_REG);

  wb_state_t                     state;
  wb_state_t                     state_nx;
  wb_entry_t                     in_entry;
  wb_entry_t                     head;
  wb_entry_t                     slot_e;
  logic [ENTRY_W-1:0]            head_bits;
  logic [WB_DEPTH-1:0][ENTRY_W-1:0] slots;
  logic [WB_DEPTH-1:0]           slot_valid;
  logic [CNT_W-1:0]              count;
  logic                          full;
  logic                          empty;
  logic                          push;
  logic                          pop;
  logic                          unused_bits;

  assign unused_bits = ^{in_inst[31:26], in_inst[21:0], empty};

  // Build the buffered entry; a call overrides both destination and data.
  always_comb begin
    in_entry       = '0;
    in_entry.is_wb = in_is_wb;
    in_entry.waddr = in_is_call ? RA_IDX : in_inst[25:22];
    if (in_is_call)
      in_entry.wdata = in_pc + PC_INC;
    else if (in_is_ld)
      in_entry.wdata = in_ld_result;
    else
      in_entry.wdata = in_alu_result;
  end

  wb_fifo #(
    .DEPTH (WB_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .wr_data    (in_entry),
    .pop        (pop),
    .rd_data    (head_bits),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .slots      (slots),
    .slot_valid (slot_valid)
  );

  assign head = wb_entry_t'(head_bits);

  // Retire decision kept outside the FSM process so in_ready -> push -> next-state has no loop.
  assign pop = ((state == ISSUE) && (!head.is_wb || rf_ack)) ||
               ((state == WAIT) && rf_ack);

  assign in_ready = !full || pop;
  assign push     = in_valid && in_ready;

  assign rf_wen   = ((state == ISSUE) && head.is_wb) || (state == WAIT);
  assign rf_waddr = rf_wen ? head.waddr : '0;
  assign rf_wdata = rf_wen ? head.wdata : '0;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: issue the head, park in WAIT until acked, then follow buffer occupancy.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (push) state_nx = ISSUE;
      ISSUE:   if (head.is_wb && !rf_ack) state_nx = WAIT;
      WAIT:    state_nx = WAIT;
      default: state_nx = IDLE;
    endcase
    if (pop)
      state_nx = ((count > CNT_W'(1)) || push) ? ISSUE : IDLE;
  end

  // Destinations still owed a write by any buffered entry.
  always_comb begin
    pending_mask = '0;
    slot_e       = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      slot_e = wb_entry_t'(slots[i]);
      if (slot_valid[i] && slot_e.is_wb)
        pending_mask[slot_e.waddr] = 1'b1;
    end
  end

  // Retire pulse and wrapping retire counter, both one cycle after the retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired      <= 1'b0;
      retire_count <= '0;
    end else begin
      retired <= pop;
      if (pop) retire_count <= retire_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus a transaction-level scoreboard.
module tb_wb_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_alu_result;
  logic [31:0] in_ld_result;
  logic        in_is_wb;
  logic        in_is_ld;
  logic        in_is_call;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ack;
  logic [15:0] pending_mask;
  logic        retired;
  logic [15:0] retire_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic        wb;
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;

  wb_unit #(
    .WB_DEPTH (DEPTH),
    .RA_REG   (15)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .in_pc         (in_pc),
    .in_alu_result (in_alu_result),
    .in_ld_result  (in_ld_result),
    .in_is_wb      (in_is_wb),
    .in_is_ld      (in_is_ld),
    .in_is_call    (in_is_call),
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rf_ack        (rf_ack),
    .pending_mask  (pending_mask),
    .retired       (retired),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_is_wb      = 1'b0;
    in_is_ld      = 1'b0;
    in_is_call    = 1'b0;
    in_inst       = '0;
    in_pc         = '0;
    in_alu_result = '0;
    in_ld_result  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    rf_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Transaction model: ordered queue of accepted entries; the head is what the
  // register file must see, and it retires when it is a store or gets acked.
  task automatic scoreboard();
    ent_t        mq[$];
    ent_t        e;
    logic        exp_ret = 1'b0;
    logic        ret_now;
    logic        hold_v = 1'b0;
    logic [3:0]  hold_a = '0;
    logic [31:0] hold_d = '0;
    logic [15:0] emask;
    int unsigned model_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        exp_ret   = 1'b0;
        hold_v    = 1'b0;
        model_cnt = 0;
      end else begin
        checks++;
        if (retired !== exp_ret) begin
          errors++;
          $display("FAIL sb_retired: got %b want %b", retired, exp_ret);
        end
        if (exp_ret && mq.size() > 0) begin
          e = mq.pop_front();
          model_cnt++;
        end
        checks++;
        if (retire_count !== model_cnt[15:0]) begin
          errors++;
          $display("FAIL sb_retire_count: got %h want %h", retire_count, model_cnt[15:0]);
        end
        emask = '0;
        foreach (mq[i]) if (mq[i].wb) emask[mq[i].a] = 1'b1;
        checks++;
        if (pending_mask !== emask) begin
          errors++;
          $display("FAIL sb_pending_mask: got %h want %h", pending_mask, emask);
        end
        if (mq.size() == 0) begin
          ret_now = 1'b0;
          checks++;
          if (rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL sb_wen_empty: got %b want 0", rf_wen);
          end
        end else begin
          ret_now = !mq[0].wb || rf_ack;
          checks++;
          if (rf_wen !== mq[0].wb) begin
            errors++;
            $display("FAIL sb_wen_head: got %b want %b", rf_wen, mq[0].wb);
          end else if (mq[0].wb) begin
            checks++;
            if (rf_waddr !== mq[0].a || rf_wdata !== mq[0].d) begin
              errors++;
              $display("FAIL sb_write: got %h/%h want %h/%h", rf_waddr, rf_wdata, mq[0].a, mq[0].d);
            end
          end
        end
        if (rf_wen === 1'b0) begin
          checks++;
          if (rf_waddr !== 4'h0 || rf_wdata !== 32'h0) begin
            errors++;
            $display("FAIL sb_idle_zero: got %h/%h want 0/0", rf_waddr, rf_wdata);
          end
        end
        if (hold_v) begin
          checks++;
          if (rf_wen !== 1'b1 || rf_waddr !== hold_a || rf_wdata !== hold_d) begin
            errors++;
            $display("FAIL sb_hold: got %b %h/%h want 1 %h/%h", rf_wen, rf_waddr, rf_wdata, hold_a, hold_d);
          end
        end
        hold_v = (rf_wen === 1'b1) && (rf_ack === 1'b0);
        hold_a = rf_waddr;
        hold_d = rf_wdata;
        checks++;
        if (in_ready !== ((mq.size() < DEPTH) || ret_now)) begin
          errors++;
          $display("FAIL sb_in_ready: got %b want %b", in_ready, (mq.size() < DEPTH) || ret_now);
        end
        exp_ret = ret_now;
        if (in_valid && in_ready) begin
          e.wb = in_is_wb;
          e.a  = in_is_call ? 4'd15 : in_inst[25:22];
          e.d  = in_is_call ? in_pc + 32'd4 : (in_is_ld ? in_ld_result : in_alu_result);
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rf_ack = 1'b0;
    #3;
    checks++;
    if (rf_wen !== 1'b0 || rf_waddr !== 4'h0 || rf_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rf: got %b %h/%h want 0 0/0", rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
    if (pending_mask !== 16'h0) begin
      errors++;
      $display("FAIL reset_pending: got %h want 0", pending_mask);
    end
    checks++;
    if (retired !== 1'b0 || retire_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_retire: got %b %h want 0 0", retired, retire_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] inst;
    tick();
    rf_ack = 1'b1;
    inst = $urandom();
    inst[25:22] = 4'd3;
    in_valid = 1'b1; in_is_wb = 1'b1; in_is_ld = 1'b0; in_is_call = 1'b0;
    in_inst = inst; in_alu_result = 32'h1234; in_ld_result = $urandom(); in_pc = $urandom();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: got ready=%b wen=%b want 1 0", in_ready, rf_wen);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL basic_write: got %b %h/%h want 1 3/00001234", rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (retired !== 1'b1 || retire_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_retire: got %b %h want 1 0001", retired, retire_count);
    end
    tick();
    @(negedge clk);
    checks++;
    if (retired !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_width: got %b want 0", retired);
    end
  endtask

  task automatic test_call();
    logic [31:0] pcs[2]  = '{32'h0000_0100, 32'hFFFF_FFFC};
    logic [31:0] want[2] = '{32'h0000_0104, 32'h0000_0000};
    for (int i = 0; i < 2; i++) begin
      tick();
      rf_ack = 1'b1;
      in_valid = 1'b1; in_is_wb = 1'b1; in_is_ld = 1'b1; in_is_call = 1'b1;
      in_pc = pcs[i]; in_inst = $urandom(); in_ld_result = $urandom(); in_alu_result = $urandom();
      @(negedge clk);
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== 4'd15 || rf_wdata !== want[i]) begin
        errors++;
        $display("FAIL call_write[%0d]: got %b %h/%h want 1 f/%h", i, rf_wen, rf_waddr, rf_wdata, want[i]);
      end
    end
    tick();
  endtask

  task automatic test_stall();
    logic [3:0]  rds[3] = '{4'd1, 4'd2, 4'd6};
    logic [3:0]  seen[$];
    logic [31:0] inst;
    int unsigned idx = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      rf_ack = (c >= 7);
      if (idx < 3) begin
        inst = $urandom();
        inst[25:22] = rds[idx];
        in_valid = 1'b1; in_is_wb = 1'b1; in_is_ld = 1'b0; in_is_call = 1'b0;
        in_inst = inst; in_alu_result = $urandom();
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (c >= 2 && c < 7) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready c=%0d: got %b want 0", c, in_ready);
        end
        checks++;
        if (pending_mask !== 16'h0006) begin
          errors++;
          $display("FAIL stall_pending c=%0d: got %h want 0006", c, pending_mask);
        end
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 4'd1) begin
          errors++;
          $display("FAIL stall_head c=%0d: got %b %h want 1 1", c, rf_wen, rf_waddr);
        end
      end
      if (rf_wen && rf_ack) seen.push_back(rf_waddr);
      if (in_valid && in_ready) idx++;
    end
    checks++;
    if (seen.size() != 3) begin
      errors++;
      $display("FAIL stall_write_count: got %0d want 3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (seen[i] !== rds[i]) begin
          errors++;
          $display("FAIL stall_order[%0d]: got %h want %h", i, seen[i], rds[i]);
        end
      end
    end
  endtask

  task automatic test_store();
    logic [3:0]  rds[3] = '{4'd4, 4'd7, 4'd9};
    logic        wbs[3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] inst;
    logic [15:0] start;
    int unsigned idx = 0;
    int unsigned wens = 0;
    tick();
    idle_inputs();
    rf_ack = 1'b1;
    @(negedge clk);
    start = retire_count;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (idx < 3) begin
        inst = $urandom();
        inst[25:22] = rds[idx];
        in_valid = 1'b1; in_is_wb = wbs[idx]; in_is_ld = wbs[idx]; in_is_call = 1'b0;
        in_inst = inst; in_ld_result = $urandom(); in_alu_result = $urandom();
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (rf_wen) begin
        wens++;
        checks++;
        if (rf_waddr === 4'd7) begin
          errors++;
          $display("FAIL store_wrote: got waddr %h want no write to 7", rf_waddr);
        end
      end
      if (in_valid && in_ready) idx++;
    end
    checks++;
    if (wens != 2) begin
      errors++;
      $display("FAIL store_wen_count: got %0d want 2", wens);
    end
    checks++;
    if (retire_count - start !== 16'd3) begin
      errors++;
      $display("FAIL store_retire_count: got %0d want 3", retire_count - start);
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] inst;
    tick();
    rf_ack = 1'b0;
    inst = $urandom();
    inst[25:22] = 4'd5;
    in_valid = 1'b1; in_is_wb = 1'b1; in_is_ld = 1'b0; in_is_call = 1'b0;
    in_inst = inst; in_alu_result = $urandom();
    @(negedge clk);
    tick();
    idle_inputs();
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (rf_wen !== 1'b1 || pending_mask !== 16'h0020) begin
      errors++;
      $display("FAIL rstwait_pre: got %b %h want 1 0020", rf_wen, pending_mask);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rf_wen !== 1'b0 || pending_mask !== 16'h0 || in_ready !== 1'b1 || retire_count !== 16'h0) begin
      errors++;
      $display("FAIL rstwait_async: got wen=%b mask=%h rdy=%b cnt=%h want 0 0 1 0",
               rf_wen, pending_mask, in_ready, retire_count);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    rf_ack = 1'b1;
    inst = $urandom();
    inst[25:22] = 4'd3;
    in_valid = 1'b1; in_is_wb = 1'b1;
    in_inst = inst; in_alu_result = 32'hCAFE_0003;
    @(negedge clk);
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 32'hCAFE_0003) begin
      errors++;
      $display("FAIL rstwait_after: got %b %h/%h want 1 3/cafe0003", rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (retired !== 1'b1 || retire_count !== 16'd1) begin
      errors++;
      $display("FAIL rstwait_count: got %b %h want 1 0001", retired, retire_count);
    end
  endtask

  task automatic test_random();
    logic [15:0] start;
    int unsigned accepted = 0;
    int unsigned drained  = 0;
    tick();
    idle_inputs();
    @(negedge clk);
    start = retire_count;
    for (int c = 0; c < 400; c++) begin
      tick();
      rf_ack        = ($urandom_range(0, 3) != 0);
      in_valid      = $urandom_range(0, 1);
      in_is_wb      = ($urandom_range(0, 3) != 0);
      in_is_ld      = $urandom_range(0, 1);
      in_is_call    = ($urandom_range(0, 7) == 0);
      in_inst       = $urandom();
      in_pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom();
      in_alu_result = $urandom();
      in_ld_result  = $urandom();
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
    end
    tick();
    idle_inputs();
    rf_ack = 1'b1;
    for (int c = 0; c < 20 && drained == 0; c++) begin
      @(negedge clk);
      if (!rf_wen && pending_mask == 16'h0 && !retired && c > 2) drained = 1;
      tick();
    end
    checks++;
    if (drained == 0) begin
      errors++;
      $display("FAIL random_drain: got busy want idle within 20 cycles");
    end
    checks++;
    if (retire_count - start !== accepted[15:0]) begin
      errors++;
      $display("FAIL random_retire_total: got %0d want %0d", retire_count - start, accepted[15:0]);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned acc = 0;
    int unsigned cyc = 0;
    do_reset();
    rf_ack = 1'b1;
    while (acc < 65537 && cyc < 70000) begin
      tick();
      in_valid      = 1'b1;
      in_is_wb      = $urandom_range(0, 1);
      in_is_ld      = $urandom_range(0, 1);
      in_is_call    = 1'b0;
      in_inst       = $urandom();
      in_alu_result = $urandom();
      in_ld_result  = $urandom();
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      cyc++;
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk);
    checks++;
    if (cyc != 65537) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d cycles want 65537 for 65537 accepts", cyc);
    end
    checks++;
    if (retire_count !== 16'd1) begin
      errors++;
      $display("FAIL b2b_wrap: got %h want 0001", retire_count);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_basic();
    test_call();
    test_stall();
    test_store();
    test_reset_wait();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 The block SHALL have parameter WB_DEPTH, default 2, meaning writeback buffer entries (power of two, >=2).
REQ-002 The block SHALL have parameter RA_REG, default 15, meaning call return-address register index.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  memory-access stage presents an instruction.
REQ-006 in_ready  output  1  block accepts the instruction this cycle.
REQ-007 in_inst  input  32  instruction word; rd = in_inst[25:22].
REQ-008 in_pc  input  32  instruction PC.
REQ-009 in_alu_result  input  32  execute-unit result.
REQ-010 in_ld_result  input  32  data-memory load result.
REQ-011 in_is_wb, in_is_ld, in_is_call  input  1 each  decode flags from the control unit.
REQ-012 rf_wen  output  1  register-file write request.
REQ-013 rf_waddr  output  4  register-file write port index.
REQ-014 rf_wdata  output  32  register-file write data.
REQ-015 rf_ack  input  1  register file accepts the write this cycle; a write completes on a cycle with rf_wen && rf_ack.
REQ-016 pending_mask  output  16  bit r set while any buffered writing entry targets register r (for operand-fetch hazard stall).
REQ-017 retired  output  1  one-cycle pulse per retired instruction.
REQ-018 retire_count  output  16  count of retired instructions.

Function
REQ-019 Accept on in_valid && in_ready; the accepted entry stores waddr = RA_REG if in_is_call else in_inst[25:22], and wdata = in_pc+4 if in_is_call, else in_ld_result if in_is_ld, else in_alu_result; in_is_call takes priority over in_is_ld.
REQ-020 Entries retire strictly in acceptance order through a WB_DEPTH FIFO.
REQ-021 FSM states: IDLE (FIFO empty), ISSUE (head present), and WAIT (write outstanding, no ack yet).
REQ-022 IDLE->ISSUE on accept; ISSUE with head is_wb=0 retires head in that cycle without asserting rf_wen; ISSUE with is_wb=1 asserts rf_wen and moves to WAIT if rf_ack=0, else retires.
REQ-023 In WAIT, rf_wen, rf_waddr and rf_wdata SHALL hold stable until the rf_ack cycle; the head retires on that cycle.
REQ-024 After a retire, the FSM SHALL go to ISSUE if the FIFO is non-empty, else to IDLE.
REQ-025 Latency: an instruction accepted at cycle N into an empty FIFO drives rf_wen at cycle N+1; throughput with rf_ack tied high is one retire per cycle.
REQ-026 in_ready SHALL be 1 when the FIFO is not full, or when it is full and the head retires this cycle (simultaneous accept and retire allowed).
REQ-027 When rf_wen=0, rf_waddr and rf_wdata SHALL be driven to 0.
REQ-028 pending_mask is combinational OR over valid FIFO entries with is_wb=1 and excludes the entry retiring this cycle only from the next cycle; a duplicate destination keeps its bit set until the last such entry retires.
REQ-029 retired pulses in the cycle after each retire; retire_count increments on the same edge and wraps 0xFFFF->0x0000.
REQ-030 Arithmetic: in_pc+4 is 32-bit modulo; 0xFFFFFFFC+4 = 0x00000000.

Reset
REQ-031 On rst_n low, immediately: FIFO emptied, FSM in IDLE, rf_wen=0, rf_waddr=0, rf_wdata=0, pending_mask=0, retired=0, retire_count=0, in_ready=1.
REQ-032 Reset asserted during WAIT SHALL drop rf_wen asynchronously and discard all entries, with no write completing.

Structure
REQ-033 Package simplerisc_pkg SHALL hold RA_REG, PC_INC=4, the register-index width (4), the data width (32) and the wb_state_t enum (IDLE, ISSUE, WAIT).
REQ-034 The FIFO SHALL be a sub-module wb_fifo (parameterised depth and entry width, async active-low reset).

Verification
REQ-035 Stimulus: reset, then add with rd=3 and alu=0x1234, rf_ack=1. Required response: rf_wen at N+1 with waddr=3 and wdata=0x1234; retired pulse at N+2; retire_count=1.
REQ-036 Stimulus: call at pc=0x100 with is_ld also set. Required response: waddr=15, wdata=0x104.
REQ-037 Stimulus: rf_ack held 0 for 5 cycles while 3 instructions are offered. Required response: outputs stable; in_ready=0 after 2 accepted; pending_mask has both rd bits set; order preserved after ack.
REQ-038 Stimulus: store (is_wb=0) between two loads. Required response: store retires with no rf_wen; retire_count=3.
REQ-039 Stimulus: rst_n pulsed low during WAIT. Required response: rf_wen=0 in the same cycle; pending_mask=0; a subsequent accept behaves as from reset.
REQ-040 Stimulus: 65537 back-to-back retires. Required response: retire_count=1.
